// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receive path: scan codes, key indices,
// frame FSM states and the scan-code to key-index lookup.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam logic [7:0] SC_ARR_U = 8'h75;
  localparam logic [7:0] SC_ARR_D = 8'h72;
  localparam logic [7:0] SC_ARR_L = 8'h6B;
  localparam logic [7:0] SC_ARR_R = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  localparam logic [1:0] KEY_R = 2'd3;
  localparam logic [1:0] KEY_L = 2'd2;
  localparam logic [1:0] KEY_D = 2'd1;
  localparam logic [1:0] KEY_U = 2'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } key_hit_t;

  // Arrow keys only count with the E0 prefix, WASD only without it.
  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = KEY_U;
    if (ext) begin
      case (code)
        SC_ARR_U: r.idx = KEY_U;
        SC_ARR_D: r.idx = KEY_D;
        SC_ARR_L: r.idx = KEY_L;
        SC_ARR_R: r.idx = KEY_R;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_W:    r.idx = KEY_U;
        SC_S:    r.idx = KEY_D;
        SC_A:    r.idx = KEY_L;
        SC_D:    r.idx = KEY_R;
        default: r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter, falling-edge strobe,
// 11-bit frame FSM with parity/stop checking and an inter-edge timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 6500,
  parameter int unsigned TW          = 13
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_ok,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  logic [1:0]            r_clk_sync, r_dat_sync;
  logic [FILTER_LEN-1:0] r_flt;
  logic                  r_filt, r_filt_d;
  logic                  w_fall, w_data;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_flt      <= '1;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_flt      <= {r_flt[FILTER_LEN-2:0], r_clk_sync[1]};
      if (&r_flt)       r_filt <= 1'b1;
      else if (~|r_flt) r_filt <= 1'b0;
      r_filt_d   <= r_filt;
    end
  end

  assign w_fall = r_filt_d & ~r_filt;
  assign w_data = r_dat_sync[1];

  rx_state_t      r_state, w_state;
  logic [2:0]     r_cnt;
  logic [7:0]     r_shift;
  logic           r_par;
  logic [TW-1:0]  r_to;
  logic           r_byte_ok, r_frame_err;
  logic           w_ok, w_err, w_timeout;

  always_comb begin
    w_state   = r_state;
    w_ok      = 1'b0;
    w_err     = 1'b0;
    w_timeout = (r_state != S_IDLE) && (r_to == TW'(TIMEOUT_CYC - 1));
    if (w_timeout) begin
      w_state = S_IDLE;
      w_err   = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_data) w_state = S_DATA;
        S_DATA:   if (r_cnt == 3'd7) w_state = S_PARITY;
        S_PARITY: w_state = S_STOP;
        S_STOP: begin
          w_state = S_IDLE;
          if (w_data && (^{r_par, r_shift})) w_ok  = 1'b1;
          else                               w_err = 1'b1;
        end
        default:  w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_to        <= '0;
      r_byte_ok   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_byte_ok   <= w_ok;
      r_frame_err <= w_err;
      if (w_fall || r_state == S_IDLE) r_to <= '0;
      else                             r_to <= r_to + 1'b1;
      if (w_fall && !w_timeout) begin
        case (r_state)
          S_IDLE: r_cnt <= '0;
          S_DATA: begin
            r_shift <= {w_data, r_shift[7:1]};
            r_cnt   <= r_cnt + 1'b1;
          end
          S_PARITY: r_par <= w_data;
          default: ;
        endcase
      end
    end
  end

  assign byte_ok   = r_byte_ok;
  assign rx_byte   = r_shift;
  assign frame_err = r_frame_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to held-key vector {R,L,D,U}: E0/F0 prefix tracking and make/break
// decoding on top of the frame receiver.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 6500,
  parameter int unsigned TW          = 13
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic       w_byte_ok, w_frame_err;
  logic [7:0] w_byte;
  key_hit_t   w_hit;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TW         (TW)
  ) u_rx (
    .pclk     (pclk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_ok  (w_byte_ok),
    .rx_byte  (w_byte),
    .frame_err(w_frame_err)
  );

  logic       r_ext, r_brk;
  logic [3:0] r_key;
  logic [7:0] r_scan_code;
  logic       r_scan_valid, r_frame_err;

  assign w_hit = key_lookup(w_byte, r_ext);

  // frame_err is registered alongside scan_valid so both share the same latency.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_key        <= '0;
      r_scan_code  <= '0;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_scan_valid <= w_byte_ok;
      r_frame_err  <= w_frame_err;
      if (w_byte_ok) begin
        r_scan_code <= w_byte;
        if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          if (w_hit.hit) r_key[w_hit.idx] <= ~r_brk;
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  assign key        = r_key;
  assign scan_code  = r_scan_code;
  assign scan_valid = r_scan_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames, with timing scaled
// down (fast PS/2 clock, short timeout) to keep the run short.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int unsigned HALF_NS = 1000;

  logic       pclk = 1'b0;
  logic       rst  = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic [3:0] key;
  } exp_t;
  exp_t q[$];

  ps2_key_decoder #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(650),
    .TW         (10)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  always #7.5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (rst && (scan_valid || frame_err)) begin
      exp_t e;
      checks++;
      if (scan_valid && frame_err) begin
        errors++;
        $display("FAIL both_pulses: scan_valid=1 frame_err=1 required exclusive");
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: scan_valid=%0b frame_err=%0b code=%h key=%b, none required",
                 scan_valid, frame_err, scan_code, key);
      end else begin
        e = q.pop_front();
        if (e.err != frame_err || (!e.err && scan_code != e.code) || key != e.key) begin
          errors++;
          $display("FAIL event: got err=%0b code=%h key=%b, required err=%0b code=%h key=%b",
                   frame_err, scan_code, key, e.err, e.code, e.key);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int unsigned nbits, input bit glitch);
    logic [10:0] f;
    f = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      #(HALF_NS);
      ps2_clk = 1'b0;
      #(HALF_NS);
      ps2_clk = 1'b1;
      if (glitch) begin
        #300;
        ps2_clk = 1'b0;
        #20;
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge pclk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d events pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic good(input logic [7:0] code, input logic [3:0] k, input bit glitch);
    q.push_back('{err: 1'b0, code: code, key: k});
    send_frame(code, 1'b0, 11, glitch);
    #(HALF_NS);
    drain("frame");
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_key"}, {4'h0, key}, 8'h00);
    chk({name, "_scan_code"}, scan_code, 8'h00);
    chk({name, "_scan_valid"}, {7'h0, scan_valid}, 8'h00);
    chk({name, "_frame_err"}, {7'h0, frame_err}, 8'h00);
  endtask

  initial begin
    #100;
    chk_all_zero("reset");
    #3;
    rst = 1'b1;
    repeat (1000) @(negedge pclk);
    chk("idle_key", {4'h0, key}, 8'h00);

    good(8'hE0, 4'b0000, 1'b0);
    good(8'h75, 4'b0001, 1'b0);
    good(8'hE0, 4'b0001, 1'b0);
    good(8'hF0, 4'b0001, 1'b0);
    good(8'h75, 4'b0000, 1'b0);

    good(8'h1D, 4'b0001, 1'b0);
    good(8'hE0, 4'b0001, 1'b0);
    good(8'h74, 4'b1001, 1'b0);
    good(8'hF0, 4'b1001, 1'b0);
    good(8'h1D, 4'b1000, 1'b0);

    q.push_back('{err: 1'b1, code: 8'h00, key: 4'b1000});
    send_frame(8'h75, 1'b1, 11, 1'b0);
    #(HALF_NS);
    drain("parity");
    good(8'h1B, 4'b1010, 1'b0);

    q.push_back('{err: 1'b1, code: 8'h00, key: 4'b1010});
    send_frame(8'h00, 1'b0, 5, 1'b0);
    ps2_data = 1'b1;
    repeat (1500) @(negedge pclk);
    drain("timeout");
    chk("timeout_scan_code", scan_code, 8'h1B);
    good(8'h1C, 4'b1110, 1'b0);

    good(8'hF0, 4'b1110, 1'b1);
    good(8'h1C, 4'b1010, 1'b1);

    send_frame(8'h1D, 1'b0, 4, 1'b0);
    #300;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    #100;
    rst = 1'b1;
    ps2_data = 1'b1;
    #(4 * HALF_NS);

    good(8'h1D, 4'b0001, 1'b0);
    good(8'hE0, 4'b0001, 1'b0);
    good(8'h6B, 4'b0101, 1'b0);
    good(8'hE0, 4'b0101, 1'b0);
    good(8'h72, 4'b0111, 1'b0);
    good(8'h75, 4'b0111, 1'b0);
    good(8'hE0, 4'b0111, 1'b0);
    good(8'h23, 4'b0111, 1'b0);
    good(8'h1D, 4'b0111, 1'b0);

    repeat (50) @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
